// File: rtl/ram_pkt_parse.sv
// ram_pkt_parse: reads one received packet from RAM port B, checks the header,
// length and payload checksum, and streams the payload bytes out on a
// valid/ready byte interface. Start and done use a level fs/fd handshake.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   fs, fd            start (level, held until fd) / done (level, until fs low)
//   ram_init          address of packet byte 0, sampled when a packet starts
//   ram_rxa, ram_rxd  RAM port-B address out / data in (one clock read latency)
//   btype, len        packet type (byte1[7:4]) and payload length {byte2,byte3}
//   dout, dout_valid, dout_ready   payload byte stream
//   err               [0] head mismatch, [1] length too large, [2] checksum mismatch
module ram_pkt_parse #(
    parameter logic [7:0]  HEAD   = 8'hAA,
    parameter logic [15:0] MAXLEN = 16'd2048,
    parameter int unsigned AW     = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fs,
    input  logic [AW-1:0] ram_init,
    output logic          fd,
    output logic [AW-1:0] ram_rxa,
    input  logic [7:0]    ram_rxd,
    output logic [3:0]    btype,
    output logic [15:0]   len,
    output logic [7:0]    dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [2:0]    err
);

    typedef enum logic [3:0] {
        IDLE, HD_A, HD_D, TY_A, TY_D, LH_A, LH_D, LL_A, LL_D,
        PL_A, PL_D, PL_H, SM_A, SM_D, DONE
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] ptr, ptr_n;
    logic [15:0]   cnt, cnt_n;
    logic [7:0]    sum, sum_n;
    logic          fd_n;
    logic [3:0]    btype_n;
    logic [15:0]   len_n;
    logic [7:0]    dout_n;
    logic          dout_valid_n;
    logic [2:0]    err_n;
    logic [15:0]   len_full;

    assign ram_rxa  = ptr;
    // Full length as seen in LL_D: high byte already stored, low byte arriving now.
    assign len_full = {len[15:8], ram_rxd};

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            sum        <= '0;
            fd         <= 1'b0;
            btype      <= '0;
            len        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            err        <= '0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            cnt        <= cnt_n;
            sum        <= sum_n;
            fd         <= fd_n;
            btype      <= btype_n;
            len        <= len_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            err        <= err_n;
        end
    end

    // Next-state and next-register logic. Each RAM byte takes an *_A cycle
    // (address presented) followed by a *_D cycle (data captured, ptr advanced).
    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        cnt_n        = cnt;
        sum_n        = sum;
        fd_n         = fd;
        btype_n      = btype;
        len_n        = len;
        dout_n       = dout;
        dout_valid_n = dout_valid;
        err_n        = err;

        if (state != IDLE && state != DONE && !fs) begin
            // Abort: outputs other than the stream keep their last values.
            state_n      = IDLE;
            dout_valid_n = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fs && !fd) begin
                        ptr_n   = ram_init;
                        err_n   = '0;
                        sum_n   = '0;
                        state_n = HD_A;
                    end
                end
                HD_A: state_n = HD_D;
                HD_D: begin
                    ptr_n = ptr + AW'(1);
                    if (ram_rxd != HEAD) begin
                        err_n[0] = 1'b1;
                        fd_n     = 1'b1;
                        state_n  = DONE;
                    end else begin
                        state_n = TY_A;
                    end
                end
                TY_A: state_n = TY_D;
                TY_D: begin
                    ptr_n   = ptr + AW'(1);
                    btype_n = ram_rxd[7:4];
                    state_n = LH_A;
                end
                LH_A: state_n = LH_D;
                LH_D: begin
                    ptr_n         = ptr + AW'(1);
                    len_n[15:8]   = ram_rxd;
                    state_n       = LL_A;
                end
                LL_A: state_n = LL_D;
                LL_D: begin
                    ptr_n = ptr + AW'(1);
                    len_n = len_full;
                    if (len_full > MAXLEN) begin
                        err_n[1] = 1'b1;
                        fd_n     = 1'b1;
                        state_n  = DONE;
                    end else if (len_full == 16'd0) begin
                        state_n = SM_A;
                    end else begin
                        cnt_n   = len_full;
                        state_n = PL_A;
                    end
                end
                PL_A: state_n = PL_D;
                PL_D: begin
                    ptr_n        = ptr + AW'(1);
                    dout_n       = ram_rxd;
                    dout_valid_n = 1'b1;
                    sum_n        = sum + ram_rxd;
                    cnt_n        = cnt - 16'd1;
                    state_n      = PL_H;
                end
                PL_H: begin
                    // dout/dout_valid stay put until the consumer takes the byte.
                    if (dout_ready) begin
                        dout_valid_n = 1'b0;
                        state_n      = (cnt == 16'd0) ? SM_A : PL_A;
                    end
                end
                SM_A: state_n = SM_D;
                SM_D: begin
                    ptr_n = ptr + AW'(1);
                    if (ram_rxd != sum) err_n[2] = 1'b1;
                    fd_n    = 1'b1;
                    state_n = DONE;
                end
                DONE: begin
                    if (!fs) begin
                        fd_n    = 1'b0;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_pkt_parse.sv
module tb_ram_pkt_parse;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs;
    logic [11:0] ram_init;
    logic        fd;
    logic [11:0] ram_rxa;
    logic [7:0]  ram_rxd;
    logic [3:0]  btype;
    logic [15:0] len;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [2:0]  err;

    logic [7:0]  mem [0:4095];
    logic [7:0]  got [$];
    int          vseen;
    int          checks = 0;
    int          errors = 0;
    int          n;

    ram_pkt_parse dut (
        .clk        (clk),
        .rst        (rst),
        .fs         (fs),
        .ram_init   (ram_init),
        .fd         (fd),
        .ram_rxa    (ram_rxa),
        .ram_rxd    (ram_rxd),
        .btype      (btype),
        .len        (len),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    // RAM port B model: data one clock after address.
    always @(posedge clk) ram_rxd <= mem[ram_rxa];

    // Collect accepted bytes and count valid cycles.
    always @(posedge clk) begin
        if (dout_valid) vseen++;
        if (dout_valid && dout_ready) got.push_back(dout);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [11:0] a, input logic [7:0] v);
        mem[a] = v;
    endtask

    task automatic put_test1(input logic [11:0] a, input logic [7:0] s);
        put(a, 8'hAA); put(a + 12'd1, 8'h90); put(a + 12'd2, 8'h00); put(a + 12'd3, 8'h03);
        put(a + 12'd4, 8'h11); put(a + 12'd5, 8'h22); put(a + 12'd6, 8'h33); put(a + 12'd7, s);
    endtask

    // Raise fs and wait (bounded) for fd.
    task automatic run_pkt(input string tag, input logic [11:0] a, output int cyc);
        got.delete();
        vseen    = 0;
        ram_init = a;
        fs       = 1'b1;
        cyc      = 0;
        while (!fd && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_fd"}, 32'(fd), 32'd1);
    endtask

    task automatic drop_fs(input string tag);
        fs = 1'b0;
        @(negedge clk);
        chk({tag, "_fd_clr"}, 32'(fd), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int c;
        c = 0;
        while (!dout_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_valid_seen"}, 32'(dout_valid), 32'd1);
    endtask

    task automatic chk_test1_bytes(input string tag);
        chk({tag, "_nbytes"}, 32'(got.size()), 32'd3);
        chk({tag, "_b0"}, 32'(got[0]), 32'h11);
        chk({tag, "_b1"}, 32'(got[1]), 32'h22);
        chk({tag, "_b2"}, 32'(got[2]), 32'h33);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        put_test1(12'h100, 8'h66);
        put(12'h200, 8'hAB); put(12'h201, 8'h90); put(12'h202, 8'h00); put(12'h203, 8'h01);
        put(12'h300, 8'hAA); put(12'h301, 8'h50); put(12'h302, 8'h00); put(12'h303, 8'h00);
        put(12'h304, 8'h00);
        put(12'h400, 8'hAA); put(12'h401, 8'h10); put(12'h402, 8'h08); put(12'h403, 8'h01);
        put_test1(12'h500, 8'h67);
        put(12'hFFE, 8'hAA); put(12'hFFF, 8'h70); put(12'h000, 8'h00); put(12'h001, 8'h02);
        put(12'h002, 8'hA5); put(12'h003, 8'h5A); put(12'h004, 8'hFF);

        rst = 1'b1; fs = 1'b0; ram_init = '0; dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_fd", 32'(fd), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_outs", {ram_rxa, btype, len}, 32'd0);
        chk("rst_dout_err", {dout, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic packet
        run_pkt("t1", 12'h100, n);
        chk_test1_bytes("t1");
        chk("t1_btype", 32'(btype), 32'd9);
        chk("t1_len", 32'(len), 32'd3);
        chk("t1_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("t1_fd_hold", 32'(fd), 32'd1);
        drop_fs("t1");

        // 2: stall consumer on byte 0x22 for 5 clocks
        got.delete();
        ram_init = 12'h100;
        fs = 1'b1;
        n = 0;
        while (!(dout_valid && dout == 8'h22) && n < 100) begin
            @(negedge clk);
            n++;
        end
        dout_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("t2_hold_dout", 32'(dout), 32'h22);
        chk("t2_hold_valid", 32'(dout_valid), 32'd1);
        dout_ready = 1'b1;
        n = 0;
        while (!fd && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t2_fd", 32'(fd), 32'd1);
        chk_test1_bytes("t2");
        chk("t2_err", 32'(err), 32'd0);
        drop_fs("t2");

        // 3a: bad header
        run_pkt("t3a", 12'h200, n);
        chk("t3a_err", 32'(err), 32'b001);
        chk("t3a_novalid", 32'(vseen), 32'd0);
        chk("t3a_fast", 32'(n <= 3), 32'd1);
        drop_fs("t3a");

        // 3b: zero length
        run_pkt("t3b", 12'h300, n);
        chk("t3b_err", 32'(err), 32'd0);
        chk("t3b_novalid", 32'(vseen), 32'd0);
        chk("t3b_len_btype", {12'd0, btype, len}, {12'd0, 4'd5, 16'd0});
        drop_fs("t3b");

        // 4a: length too large
        run_pkt("t4a", 12'h400, n);
        chk("t4a_err", 32'(err), 32'b010);
        chk("t4a_novalid", 32'(vseen), 32'd0);
        chk("t4a_len", 32'(len), 32'h0801);
        drop_fs("t4a");

        // 4b: bad checksum
        run_pkt("t4b", 12'h500, n);
        chk("t4b_err", 32'(err), 32'b100);
        chk_test1_bytes("t4b");
        drop_fs("t4b");

        // 5: address wrap
        run_pkt("t5", 12'hFFE, n);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_len_btype", {12'd0, btype, len}, {12'd0, 4'd7, 16'd2});
        chk("t5_nbytes", 32'(got.size()), 32'd2);
        chk("t5_b0", 32'(got[0]), 32'hA5);
        chk("t5_b1", 32'(got[1]), 32'h5A);
        drop_fs("t5");

        // 6a: abort by dropping fs while a byte is held
        got.delete();
        dout_ready = 1'b0;
        ram_init = 12'h100;
        fs = 1'b1;
        wait_valid("t6a");
        fs = 1'b0;
        @(negedge clk);
        chk("t6a_valid", 32'(dout_valid), 32'd0);
        chk("t6a_fd", 32'(fd), 32'd0);
        dout_ready = 1'b1;
        @(negedge clk);
        run_pkt("t6a_rerun", 12'h100, n);
        chk_test1_bytes("t6a_rerun");
        chk("t6a_rerun_err", 32'(err), 32'd0);
        drop_fs("t6a_rerun");

        // 6b: asynchronous reset mid-payload
        dout_ready = 1'b0;
        ram_init = 12'h100;
        fs = 1'b1;
        wait_valid("t6b");
        rst = 1'b1;
        #1;
        chk("t6b_valid", 32'(dout_valid), 32'd0);
        chk("t6b_fd", 32'(fd), 32'd0);
        chk("t6b_outs", {ram_rxa, btype, len}, 32'd0);
        chk("t6b_dout_err", {dout, err}, 32'd0);
        fs = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_pkt("t6b_rerun", 12'h100, n);
        chk_test1_bytes("t6b_rerun");
        chk("t6b_rerun_err", 32'(err), 32'd0);
        chk("t6b_rerun_btype", 32'(btype), 32'd9);
        drop_fs("t6b_rerun");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
